dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arbiter_sat_counter.sv | 28 ++
 rtl/dmem_arbiter.sv | 105 ++++++++++
 tb/tb_dmem_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: bus ownership encoding
// and master index constants used to address the grant vector.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  localparam int unsigned N_MASTERS = 2;
  localparam bit          M0_IDX    = 1'b0;
  localparam bit          M1_IDX    = 1'b1;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; reports when it sits at MAX.
module sat_counter #(
  parameter int unsigned MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == W'(MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master zero-wait arbiter for a combinational-read data memory:
// m0 (CPU) has priority, m1 gets starvation relief and bounded locked bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned LOCK_MAX   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e                 owner_q, owner_d;
  logic                   yield_q, yield_d;
  logic                   starve_max, lock_max;
  logic                   force_m1, lock_hold;
  logic [N_MASTERS-1:0]   gnt;
  logic                   rd_gnt;

  // yield_q marks the single m0 slot taken out of a full locked burst, so the
  // burst may resume next cycle even though ownership passed through M0.
  always_comb begin
    gnt       = '0;
    owner_d   = OWN_IDLE;
    force_m1  = m1_req && starve_max;
    lock_hold = m1_req && m1_lock && !lock_max &&
                ((owner_q == OWN_M1) || yield_q);
    if (m0_req && !force_m1 && !lock_hold) begin
      gnt[M0_IDX] = 1'b1;
      owner_d     = OWN_M0;
    end else if (m1_req) begin
      gnt[M1_IDX] = 1'b1;
      owner_d     = OWN_M1;
    end
    yield_d = gnt[M0_IDX] && lock_max && m1_req && m1_lock;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_IDLE;
      yield_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      yield_q <= yield_d;
    end
  end

  sat_counter #(.MAX(STARVE_MAX)) u_starve_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .clr    (!m1_req || gnt[M1_IDX]),
    .inc    (m1_req && !gnt[M1_IDX]),
    .at_max (starve_max)
  );

  sat_counter #(.MAX(LOCK_MAX)) u_lock_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .clr    (gnt[M0_IDX] || !m1_lock || !m1_req),
    .inc    (gnt[M1_IDX] && m1_lock),
    .at_max (lock_max)
  );

  assign m0_gnt    = gnt[M0_IDX];
  assign m1_gnt    = gnt[M1_IDX];
  assign mem_we    = (gnt[M0_IDX] && m0_we) || (gnt[M1_IDX] && m1_we);
  assign mem_addr  = gnt[M1_IDX] ? m1_addr  : m0_addr;
  assign mem_wdata = gnt[M1_IDX] ? m1_wdata : m0_wdata;
  assign rd_gnt    = (gnt[M0_IDX] && !m0_we) || (gnt[M1_IDX] && !m1_we);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata   <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt[M0_IDX] && !m0_we;
      rvalid1 <= gnt[M1_IDX] && !m1_we;
      if (rd_gnt) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a cycle-level
// behavioural model of ownership, starvation relief and burst limits.
module tb_dmem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int          SMAX = 8;
  localparam int          LMAX = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m0_gnt;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m1_req, m1_lock, m1_we, m1_gnt;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] rdata;
  logic          rvalid0, rvalid1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  dmem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX),
    .LOCK_MAX   (LMAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m1_req    (m1_req),
    .m1_lock   (m1_lock),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .rdata     (rdata),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Bench-owned DMEM: combinational read, write on the clock edge.
  logic [DW-1:0] dmem [256];
  bit            filled = 1'b0;
  assign mem_rdata = dmem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 256; i++) dmem[i] <= $urandom;
      filled <= 1'b1;
    end else if (mem_we) begin
      dmem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  // Reference state: who held the bus, how long m1 has waited, burst length.
  int            m_owner;   // 0 none, 1 m0, 2 m1
  int            m_starve;
  int            m_lock;
  bit            m_yield;
  bit            e_rv0, e_rv1;
  logic [DW-1:0] e_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_starve = 0;
    m_lock   = 0;
    m_yield  = 1'b0;
    e_rv0    = 1'b0;
    e_rv1    = 1'b0;
    e_rdata  = '0;
  endtask

  // m0 wins unless m1 has starved long enough or is inside a burst that
  // still has budget (burst continues after its one forced m0 slot).
  function automatic int model_grant();
    bit starved, in_burst;
    starved  = m1_req && (m_starve >= SMAX);
    in_burst = m1_req && m1_lock && (m_owner == 2 || m_yield) && (m_lock < LMAX);
    if (m0_req && !starved && !in_burst) return 1;
    if (m1_req) return 2;
    return 0;
  endfunction

  task automatic step(input bit r0, input bit w0, input logic [7:0] a0, input logic [31:0] d0,
                      input bit r1, input bit l1, input bit w1, input logic [7:0] a1,
                      input logic [31:0] d1, output int g);
    @(negedge clk);
    m0_req = r0; m0_we = w0; m0_addr = {24'h0, a0}; m0_wdata = d0;
    m1_req = r1; m1_lock = l1; m1_we = w1; m1_addr = {24'h0, a1}; m1_wdata = d1;
    #1;
    chk("rvalid0", rvalid0, e_rv0);
    chk("rvalid1", rvalid1, e_rv1);
    chk("rdata", rdata, e_rdata);
    g = model_grant();
    chk("m0_gnt", m0_gnt, (g == 1));
    chk("m1_gnt", m1_gnt, (g == 2));
    chk("gnt_exclusive", (m0_gnt & m1_gnt), 0);
    if (g == 0) begin
      chk("idle_mem_we", mem_we, 0);
    end else begin
      chk("mem_we", mem_we, (g == 1) ? w0 : w1);
      chk("mem_addr", mem_addr, {24'h0, (g == 1) ? a0 : a1});
      if ((g == 1) ? w0 : w1) chk("mem_wdata", mem_wdata, (g == 1) ? d0 : d1);
    end
    e_rv0 = (g == 1) && !w0;
    e_rv1 = (g == 2) && !w1;
    if (e_rv0 || e_rv1) e_rdata = dmem[(g == 1) ? a0 : a1];
    m_yield = (g == 1) && (m_lock >= LMAX) && r1 && l1;
    if (r1 && g != 2) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
    else              m_starve = 0;
    if (g == 1 || !r1 || !l1) m_lock = 0;
    else if (g == 2 && m_lock < LMAX) m_lock++;
    m_owner = g;
  endtask

  task automatic idle_step(output int g);
    step(0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h0, g);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    int            g, first_m1, resumed, n1, lead;
    int            seq[$];
    logic [DW-1:0] exp_d;

    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rvalid0", rvalid0, 0);
    chk("reset_rvalid1", rvalid1, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_m0_gnt", m0_gnt, 0);
    chk("reset_m1_gnt", m1_gnt, 0);
    chk("reset_mem_we", mem_we, 0);
    @(negedge clk);
    reset = 1'b1;

    // Lone m0 read: same-cycle grant, data one cycle later.
    exp_d = dmem[8'h10];
    step(1, 0, 8'h10, 32'h0, 0, 0, 0, 8'h00, 32'h0, g);
    chk("rd10_m0_gnt", m0_gnt, 1);
    idle_step(g);
    chk("rd10_rdata", rdata, exp_d);
    chk("rd10_rvalid0", rvalid0, 1);
    chk("rd10_rvalid1", rvalid1, 0);

    // Both masters contend without lock: m1 relieved on the 9th cycle.
    first_m1 = 0;
    resumed  = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1, 0, 8'($urandom), 32'h0, 1, 0, 0, 8'($urandom), 32'h0, g);
      if (m1_gnt && first_m1 == 0) first_m1 = i;
      if (i == 10) resumed = m0_gnt;
    end
    chk("starve_first_m1", first_m1, 9);
    chk("starve_m0_resumes", resumed, 1);
    idle_step(g);

    // Locked m1 write burst of 20 with m0 joining after the first beat.
    n1 = 0;
    for (int i = 0; i < 60 && n1 < 20; i++) begin
      step((i > 0), 0, 8'($urandom), 32'h0, 1, 1, 1, 8'(i), $urandom, g);
      if (m1_gnt) begin n1++; seq.push_back(2); end
      else if (m0_gnt) seq.push_back(1);
    end
    chk("burst_m1_total", n1, 20);
    lead = 0;
    while (lead < seq.size() && seq[lead] == 2) lead++;
    chk("burst_lead_m1", lead, 16);
    chk("burst_m0_slot", (seq.size() > 17) ? seq[16] : 0, 1);
    chk("burst_m1_regain", (seq.size() > 17) ? seq[17] : 0, 2);
    idle_step(g);

    // m1 write then m0 read back through the arbiter.
    step(0, 0, 8'h00, 32'h0, 1, 0, 1, 8'h40, 32'hDEADBEEF, g);
    step(1, 0, 8'h40, 32'h0, 0, 0, 0, 8'h00, 32'h0, g);
    idle_step(g);
    chk("wr40_rdata", rdata, 32'hDEADBEEF);
    chk("wr40_rvalid0", rvalid0, 1);
    chk("wr40_rvalid1", rvalid1, 0);

    // Reset in the middle of a locked m1 read burst.
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 32'h0, 1, 1, 0, 8'(i), 32'h0, g);
    m0_req = 1'b1;
    reset  = 1'b0;
    #1;
    chk("rst_burst_rvalid1", rvalid1, 0);
    chk("rst_burst_rvalid0", rvalid0, 0);
    chk("rst_burst_rdata", rdata, 0);
    chk("rst_burst_m0_gnt", m0_gnt, 1);
    chk("rst_burst_m1_gnt", m1_gnt, 0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    step(1, 0, 8'h20, 32'h0, 1, 1, 0, 8'h21, 32'h0, g);
    chk("post_rst_m0_first", m0_gnt, 1);

    // Randomized traffic, biased toward long m1 bursts to reach both limits.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 8'($urandom), $urandom,
           ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) != 0), $urandom_range(0, 1),
           8'($urandom), $urandom, g);
    end
    idle_step(g);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
